seq_mult_ctrl: RTL and testbench
================================

Name: seq_mult_ctrl

Overview:
- Sequencer for an iterative shift-add unsigned multiplier inside the ALU/EX stage.
- Loads operands on a start pulse and steps the accumulate/shift datapath one bit per cycle.
- Uses a zero-detect OR-reduction on the remaining multiplier to end early.
- Signals completion to the pipeline stall logic.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  single-cycle request to begin a multiply; honoured only when ready=1
- a  input  WIDTH  multiplicand, sampled on an accepted start
- b  input  WIDTH  multiplier, sampled on an accepted start
- ready  output  1  high in IDLE and DONE; a start may be accepted
- busy  output  1  high in RUN; EX stage stalls on this
- done  output  1  one-cycle pulse when product becomes valid
- product  output  2*WIDTH  unsigned a*b; held until the next accepted start
- zero  output  1  product == 0; valid with done and held with product
- iters  output  CNT_W  number of RUN cycles used by the last operation

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, ready=1, busy=0, done=0, product=0, zero=1, iters=0, and all internal registers 0.
- States and transitions:
  - IDLE: on start, go to RUN. Load mcand={WIDTH'b0,a}, mplier=b, acc=0, cnt=0.
  - RUN, each cycle:
    - If mplier[0]=1, acc <= acc+mcand. The add is 2*WIDTH-bit and wraps modulo 2^(2*WIDTH); it cannot overflow for valid operands.
    - mcand <= mcand<<1, mplier <= mplier>>1, cnt <= cnt+1.
    - Terminate when the shifted mplier is 0 (OR-reduce == 0) or cnt+1 == WIDTH.
    - On termination go to DONE and register product=acc_next, zero=~|acc_next, iters=cnt+1.
  - DONE: lasts exactly one cycle with done=1. Then go to IDLE, or back to RUN if start is high in that cycle (back-to-back operation).
- Latency from start to done = iters+1 cycles.
  - iters = index of the highest set bit of b, plus 1.
  - b=0 gives iters=1; b with the MSB set gives iters=WIDTH.
- start while busy=1 is ignored, with no queuing. a and b are don't-care outside an accepted start.
- rst asserted in RUN abandons the operation. The next cycle is IDLE with reset values; no done pulse occurs.
- rst and start asserted in the same cycle: rst wins.
- product, zero and iters change only on termination or reset.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: early termination on remaining-multiplier-zero, as described above.
- Undefined: the zero-detect is not used. RUN always lasts WIDTH cycles, iters=WIDTH, and latency is fixed at WIDTH+1. Product values are identical in both builds.

Decomposition:
- Shared package/header holds:
  - state encoding constants: S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - the default WIDTH and CNT_W.
- One natural sub-module: zero_detect_w, a parameterised WIDTH-bit OR-reduce with inverted output. It is instantiated for mplier_next and again for acc_next.
- FSM and datapath stay in seq_mult_ctrl.

Test Plan:
- Reset: hold rst for 3 cycles, then release → ready=1, busy=0, done=0, product=0, zero=1, iters=0.
- Basic case: a=7, b=6, start → busy for 3 cycles, done at cycle 4, product=42, zero=0, iters=3. With the macro undefined: iters=32, done at cycle 33.
- Zero and extreme operands:
  - b=0, a=0xFFFFFFFF → iters=1, product=0, zero=1.
  - a=b=0xFFFFFFFF → iters=32, product=0xFFFFFFFE00000001.
- Back-to-back: start asserted in the DONE cycle with a=3, b=5 → the next operation begins without an IDLE cycle; product=15, iters=3.
- Busy start: start pulses during RUN with a=9, b=9 → ignored; the original result is unchanged and only one done pulse occurs.
- Reset mid-run: a=1, b=0x80000000, rst at RUN cycle 10 → no done pulse; state IDLE; product=0. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/seq_mult_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// seq_mult_ctrl_pkg
// Shared definitions for the iterative shift-add multiplier sequencer:
//   - default operand width and iteration-counter width
//   - FSM state encoding (IDLE / RUN / DONE)
// No ports; imported by seq_mult_ctrl.
// ---------------------------------------------------------------------------
package seq_mult_ctrl_pkg;

  // Default operand width; the product is twice this width.
  localparam int SEQ_MULT_WIDTH = 32;

  // Iteration counter width; 2**CNT_W must exceed the operand width.
  localparam int SEQ_MULT_CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_ctrl_zero_detect.sv
// ---------------------------------------------------------------------------
// zero_detect_w
// Parameterised zero detector: OR-reduce of a WIDTH-bit vector, inverted.
// Ports:
//   value   [WIDTH-1:0] in   vector to test
//   is_zero             out  1 when every bit of value is 0
// ---------------------------------------------------------------------------
module zero_detect_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic             is_zero
);

  assign is_zero = ~|value;

endmodule

// File: rtl/seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mult_ctrl
// Sequencer and datapath for an iterative shift-add unsigned multiplier used
// in the EX stage. One multiplier bit is consumed per RUN cycle; the EX stage
// stalls while busy is high and picks up the product on the done pulse.
//
// Build option (macro SEQ_MULT_EARLY_TERM_EN):
//   defined   - RUN ends as soon as the remaining multiplier shifts to zero,
//               so iters = index of highest set bit of b, plus 1 (1 for b=0).
//   undefined - RUN always lasts WIDTH cycles; iters = WIDTH.
//   The product is identical in both builds.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   request a multiply; accepted only while ready=1
//   a        in   [WIDTH-1:0]   multiplicand, sampled on accepted start
//   b        in   [WIDTH-1:0]   multiplier, sampled on accepted start
//   ready    out  high in IDLE and DONE
//   busy     out  high in RUN
//   done     out  one-cycle pulse when product becomes valid
//   product  out  [2*WIDTH-1:0] a*b, held until the next termination/reset
//   zero     out  product == 0, held with product
//   iters    out  [CNT_W-1:0]   RUN cycles used by the last operation
// ---------------------------------------------------------------------------
module seq_mult_ctrl
  import seq_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_WIDTH,
  parameter int CNT_W = SEQ_MULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 zero,
  output logic [CNT_W-1:0]     iters
);

  state_t state_reg, state_next;

  logic [2*WIDTH-1:0] mcand_reg, mcand_next;
  logic [WIDTH-1:0]   mplier_reg, mplier_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] product_reg, product_next;
  logic               zero_reg, zero_next;
  logic [CNT_W-1:0]   iters_reg, iters_next;

  // Values the datapath would take at the end of the current RUN cycle.
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier_shift;
  logic [CNT_W-1:0]   cnt_inc;
  logic               acc_step_zero;
  logic               last_iter;
  logic               terminate;

  // Partial-product accumulate; wraps modulo 2^(2*WIDTH), which a valid
  // product can never reach.
  assign acc_step     = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign mplier_shift = mplier_reg >> 1;
  assign cnt_inc      = cnt_reg + CNT_W'(1);
  assign last_iter    = (cnt_inc == CNT_W'(WIDTH));

  // zero flag is computed from the value being registered as the product.
  zero_detect_w #(
    .WIDTH (2*WIDTH)
  ) u_acc_zero (
    .value   (acc_step),
    .is_zero (acc_step_zero)
  );

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic mplier_shift_zero;

  // Once the remaining multiplier is all zeros no further adds can occur,
  // so the accumulator already holds the final product.
  zero_detect_w #(
    .WIDTH (WIDTH)
  ) u_mplier_zero (
    .value   (mplier_shift),
    .is_zero (mplier_shift_zero)
  );

  assign terminate = last_iter | mplier_shift_zero;
`else
  assign terminate = last_iter;
`endif

  // Next-state, datapath and output decode.
  always_comb begin
    state_next   = state_reg;
    mcand_next   = mcand_reg;
    mplier_next  = mplier_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    product_next = product_reg;
    zero_next    = zero_reg;
    iters_next   = iters_reg;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next  = S_RUN;
          mcand_next  = {{WIDTH{1'b0}}, a};
          mplier_next = b;
          acc_next    = '0;
          cnt_next    = '0;
        end
      end

      S_RUN: begin
        busy        = 1'b1;
        acc_next    = acc_step;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_shift;
        cnt_next    = cnt_inc;
        if (terminate) begin
          state_next   = S_DONE;
          product_next = acc_step;
          zero_next    = acc_step_zero;
          iters_next   = cnt_inc;
        end
      end

      S_DONE: begin
        ready      = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
        // Back-to-back: a start here skips the IDLE cycle.
        if (start) begin
          state_next  = S_RUN;
          mcand_next  = {{WIDTH{1'b0}}, a};
          mplier_next = b;
          acc_next    = '0;
          cnt_next    = '0;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
      zero_reg    <= 1'b1;
      iters_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      mcand_reg   <= mcand_next;
      mplier_reg  <= mplier_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      product_reg <= product_next;
      zero_reg    <= zero_next;
      iters_reg   <= iters_next;
    end
  end

  assign product = product_reg;
  assign zero    = zero_reg;
  assign iters   = iters_reg;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_ctrl
// Self-checking bench for seq_mult_ctrl. A table of operand/product records
// is applied in a loop; expected results are queued when a start is driven
// and popped when done is seen. Hand-written sequences cover back-to-back
// starts, starts while busy and reset in the middle of a run. Expected
// iteration counts follow the SEQ_MULT_EARLY_TERM_EN build option.
// ---------------------------------------------------------------------------
module tb_seq_mult_ctrl;

  localparam int W  = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ready;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;
  logic          zero;
  logic [CW-1:0] iters;

  always #5 clk = ~clk;

  seq_mult_ctrl #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product),
    .zero    (zero),
    .iters   (iters)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] prod;
    logic        zero;
    int          iters;
    int          latency;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic        zero;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference iteration count, independent of the DUT's counter.
  function automatic int exp_iters(input logic [31:0] bv);
    int n;
`ifdef SEQ_MULT_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < W; i++) begin
      if (bv[i]) n = i + 1;
    end
`else
    n = W;
`endif
    return n;
  endfunction

  // Drive one multiply from a negedge and follow it to its done pulse.
  // Returns at the negedge where done is observed (state DONE).
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] ep, input logic ez, input bit poke_busy);
    exp_t e;
    exp_t got;
    bit   seen;
    check("ready_at_start", ready, 1'b1);
    start = 1'b1;
    a     = av;
    b     = bv;
    e.prod    = ep;
    e.zero    = ez;
    e.iters   = exp_iters(bv);
    e.latency = e.iters + 1;
    sb.push_back(e);
    seen = 1'b0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      if (k == 1) check("busy_after_start", busy, 1'b1);
      if (done) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
        end else begin
          got = sb.pop_front();
          check("latency", 64'(k), 64'(got.latency));
          check("product", product, got.prod);
          check("zero", zero, got.zero);
          check("iters", 64'(iters), 64'(got.iters));
          $display("op a=0x%08h b=0x%08h product=0x%016h zero=%0d iters=%0d latency=%0d",
                   av, bv, product, zero, iters, k);
        end
      end else if (poke_busy && k == 2) begin
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd9;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in 200 cycles, expected done");
      sb.delete();
    end
  endtask

  // Quiet cycles: no done pulse and no activity may appear.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("no_spurious_done", done, 1'b0);
      check("idle_not_busy", busy, 1'b0);
    end
  endtask

  task automatic check_reset_state();
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_product", product, 64'd0);
    check("rst_zero", zero, 1'b1);
    check("rst_iters", 64'(iters), 64'd0);
  endtask

  initial begin
    vecs[0] = '{a: 32'd7,          b: 32'd6,          prod: 64'd42,                  zero: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd0,          prod: 64'd0,                   zero: 1'b1};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  prod: 64'hFFFF_FFFE_0000_0001, zero: 1'b0};
    vecs[3] = '{a: 32'd1,          b: 32'h8000_0000,  prod: 64'h0000_0000_8000_0000, zero: 1'b0};
    vecs[4] = '{a: 32'h1234_5678,  b: 32'd9,          prod: 64'h0000_0000_A3D7_0A38, zero: 1'b0};
    vecs[5] = '{a: 32'd0,          b: 32'd5,          prod: 64'd0,                   zero: 1'b1};
    vecs[6] = '{a: 32'h0001_0000,  b: 32'h0001_0000,  prod: 64'h0000_0001_0000_0000, zero: 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state();
    $display("reset released");

    // Table-driven operations, each followed by a held-result check.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].zero, 1'b0);
      idle(1);
      check("product_hold", product, vecs[i].prod);
    end

    // Back-to-back: second start lands in the DONE cycle of the first.
    run_op(32'd7, 32'd6, 64'd42, 1'b0, 1'b0);
    run_op(32'd3, 32'd5, 64'd15, 1'b0, 1'b0);
    idle(2);

    // Start pulse during RUN must be ignored: one done, original result.
    run_op(32'd7, 32'h0000_00F0, 64'd1680, 1'b0, 1'b1);
    idle(3);
    check("busy_start_product", product, 64'd1680);
    check("busy_start_iters", 64'(iters), 64'(exp_iters(32'h0000_00F0)));
    check("busy_start_sb_empty", 64'(sb.size()), 64'd0);

    // Reset in RUN cycle 10 abandons the operation.
    start = 1'b1;
    a     = 32'd1;
    b     = 32'h8000_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("midrun_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state();
    $display("reset during run applied");
    idle(40);
    check("midrun_product_cleared", product, 64'd0);

    // A fresh operation after the abort completes normally.
    run_op(32'd1, 32'h8000_0000, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
